uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single `uart_tx` transmitter between two bus requesters, for example two harts or a debug port and a core. Each requester sees an ordinary memory-mapped UART. The block latches each requester's write byte and grants the transmitter round-robin. It issues one byte at a time and holds off the requester's `mem_ready` until `uart_tx` signals that the byte has been sent. It sits between the peripheral decode and the `uart_tx` instance.

## Interface
- `timeout`, default 1048576: maximum cycles to wait for `uart_tx` `mem_ready` after an issue. Used only with `UART_ARB_TIMEOUT_EN`.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_in`  in  `mem_in_type`  requester 0 bus request.
- `req0_out`  out  `mem_out_type`  requester 0 response.
- `req1_in`  in  `mem_in_type`  requester 1 bus request.
- `req1_out`  out  `mem_out_type`  requester 1 response.
- `uart_in`  out  `mem_in_type`  request to `uart_tx`.
- `uart_out`  in  `mem_out_type`  response from `uart_tx`.

## Operation
- **Per-port slot**
  - Each port has a slot: `pend`, 1 bit, and `byte`, 8 bits.
  - A `mem_valid` with `|mem_wstrb=1` while `pend=0` sets `pend` and captures `mem_wdata[7:0]`.
  - A `mem_valid` with `mem_wstrb=0` is a read. It is not forwarded. The port gets `mem_rdata=0`, `mem_error=0`, `mem_ready=1` on the next cycle.
  - A `mem_valid` while `pend=1` is a protocol violation. It is ignored: no capture and no response.
- **Round-robin pointer `last`** (1 bit, reset 1)
  - If both slots are pending, grant the port that is not `last`.
  - If only one slot is pending, grant that port.
  - On completion, set `last` to the granted port.
- **FSM `state`**: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any `pend`, latch `grant` and go to ISSUE.
  - ISSUE: drive `uart_in.mem_valid=1`, `mem_wdata={24'b0,byte}`, `mem_wstrb=4'b0001`, all other fields 0. Go to WAIT.
  - WAIT: on `uart_out.mem_ready=1`, go to RESP.
  - RESP: pulse `mem_ready=1` with `mem_error=0` on the granted port. Clear its `pend`, update `last`, go to IDLE.
- **Capture during a transfer**: a slot may be captured in any state, including the same cycle its port's pending byte is being issued by the other path.
- **Stray ready**: `uart_out.mem_ready` seen outside WAIT is ignored.
- **Simultaneous events on one port**: a read response and the RESP write response never coincide, because the port is blocked while `pend=1`.
- **Reset mid-transfer**: all slots clear, `state=IDLE`, `last=1`. A byte already in `uart_tx` completes on the line; its late ready is ignored.

## Timing
- All outputs are registered.
- **Reset values**:
  - all `mem_ready`, `mem_error`, `mem_rdata` = 0;
  - `uart_in.mem_valid=0` and all `uart_in` fields = 0.
- **Write latency**:
  - valid sampled in cycle t; IDLE→ISSUE at t+1; `uart_in.mem_valid` high during cycle t+2 only;
  - `uart_tx` ready seen in cycle u; requester `mem_ready` high during cycle u+2.
- **Back-to-back grant**: minimum 4 cycles between consecutive `uart_in.mem_valid` pulses, plus the `uart_tx` frame time.
- **Read latency**: 1 cycle.
- `uart_in.mem_valid` is exactly one cycle per granted byte.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined**
  - A 32-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `timeout-1` without ready, go to RESP with `mem_error=1`, `mem_ready=1` on the granted port. The slot is then cleared and `last` updated.
- **`UART_ARB_TIMEOUT_EN` undefined**: no counter; WAIT waits indefinitely, and `mem_error` is always 0.

## Structure
- The FSM state enum and the register struct (`state`, `grant`, `last`, slots, `counter`) go in package `wires`.
- The default `timeout` constant goes in `configure`.
- One sub-module is natural: `uart_arb_slot`, the per-port capture/pending/read-response logic, instantiated twice.

## Test plan
- **Single write**: `req0` write 0x41, `uart_tx` ready 10 cycles after issue → one `uart_in` pulse with `wdata=0x41`, `wstrb=0x1`; `req0_out.mem_ready` 2 cycles after the `uart_tx` ready.
- **Simultaneous writes**: `req0`=0x30 and `req1`=0x31 in the same cycle after reset → 0x30 issued first, then 0x31; each port gets exactly one ready.
- **Fairness**: `req0` and `req1` both keep re-requesting continuously → issued bytes strictly alternate 0,1,0,1 across 8 bytes.
- **Read**: `req1` valid with `wstrb=0` while port 0 is in WAIT → `req1_out` ready next cycle with `rdata=0`; no `uart_in` pulse.
- **Reset mid-WAIT**: reset for 1 cycle → all outputs 0; a later `uart_tx` ready is ignored; next `req1` write 0x55 completes normally.
- **Timeout** (macro on, `timeout=16`, `uart_tx` never ready) → `req0_out.mem_error=1`, `mem_ready=1` after 16 WAIT cycles; a subsequent write is issued.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for uart_tx_arbiter: bus structs, FSM state, register struct.
// configure holds the default uart_tx ready timeout.
package configure;

    localparam logic [31:0] uart_arb_timeout = 32'd1048576;

endpackage

package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       pend;
        logic [7:0] wbyte;
    } slot_t;

    typedef struct packed {
        arb_state_t  state;
        logic        grant;
        logic        last;
        logic        err;
        logic [31:0] counter;
    } arb_reg_t;

    localparam arb_reg_t ARB_RESET = '{
        state:   IDLE,
        grant:   1'b0,
        last:    1'b1,
        err:     1'b0,
        counter: 32'd0
    };

    // Both pending: the port that was not served last wins.
    function automatic logic pick(input logic p0, input logic p1,
                                  input logic last);
        return (p0 & p1) ? ~last : p1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_slot.sv
// uart_arb_slot: per-port write capture, pending flag and read response.
module uart_arb_slot
    import wires::*;
(
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  req_in,
    output mem_out_type req_out,
    input  logic        done,
    input  logic        error,
    output logic        pend,
    output logic [7:0]  wbyte
);

    slot_t       slot_q, slot_d;
    mem_out_type out_q, out_d;
    logic        accept;
    logic        unused_ok;

    assign unused_ok = ^{req_in.mem_instr, req_in.mem_addr,
                         req_in.mem_wdata[31:8]};

    // The cycle a response is presented the requester still holds valid,
    // so that request is already being answered and must not be re-taken.
    always_comb begin
        slot_d = slot_q;
        out_d  = '0;
        accept = req_in.mem_valid && !slot_q.pend && !out_q.mem_ready;
        if (done) begin
            slot_d.pend = 1'b0;
        end
        if (accept && |req_in.mem_wstrb) begin
            slot_d.pend  = 1'b1;
            slot_d.wbyte = req_in.mem_wdata[7:0];
        end
        out_d.mem_ready = done | (accept && req_in.mem_wstrb == 4'b0000);
        out_d.mem_error = done & error;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q <= '0;
            out_q  <= '0;
        end else begin
            slot_q <= slot_d;
            out_q  <= out_d;
        end
    end

    assign req_out = out_q;
    assign pend    = slot_q.pend;
    assign wbyte   = slot_q.wbyte;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between two requesters.
// Define UART_ARB_TIMEOUT_EN to bound the wait for uart_tx ready.
module uart_tx_arbiter
    import configure::*;
    import wires::*;
#(
    parameter logic [31:0] timeout = uart_arb_timeout
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  req0_in,
    output mem_out_type req0_out,
    input  mem_in_type  req1_in,
    output mem_out_type req1_out,
    output mem_in_type  uart_in,
    input  mem_out_type uart_out
);

    arb_reg_t   r_q, r_d;
    mem_in_type uart_q, uart_d;
    logic [1:0] pend;
    logic [1:0] done;
    logic [7:0] byte0, byte1;
    logic       gnt;
    logic       unused_ok;

    assign unused_ok = ^{uart_out.mem_error, uart_out.mem_rdata, timeout};

    uart_arb_slot u_slot0 (
        .clock   (clock),
        .reset   (reset),
        .req_in  (req0_in),
        .req_out (req0_out),
        .done    (done[0]),
        .error   (r_q.err),
        .pend    (pend[0]),
        .wbyte   (byte0)
    );

    uart_arb_slot u_slot1 (
        .clock   (clock),
        .reset   (reset),
        .req_in  (req1_in),
        .req_out (req1_out),
        .done    (done[1]),
        .error   (r_q.err),
        .pend    (pend[1]),
        .wbyte   (byte1)
    );

    // uart_in is registered: it is loaded on IDLE->ISSUE so it is high
    // for exactly the ISSUE cycle.
    always_comb begin
        r_d    = r_q;
        uart_d = '0;
        done   = 2'b00;
        gnt    = pick(pend[0], pend[1], r_q.last);
        unique case (r_q.state)
            IDLE: begin
                if (|pend) begin
                    r_d.grant        = gnt;
                    r_d.err          = 1'b0;
                    r_d.state        = ISSUE;
                    uart_d.mem_valid = 1'b1;
                    uart_d.mem_wdata = {24'b0, gnt ? byte1 : byte0};
                    uart_d.mem_wstrb = 4'b0001;
                end
            end
            ISSUE: begin
                r_d.state   = WAIT;
                r_d.counter = '0;
            end
            WAIT: begin
                if (uart_out.mem_ready) begin
                    r_d.state = RESP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (r_q.counter == timeout - 32'd1) begin
                    r_d.state = RESP;
                    r_d.err   = 1'b1;
                end else begin
                    r_d.counter = r_q.counter + 32'd1;
                end
`else
`endif
            end
            RESP: begin
                done      = r_q.grant ? 2'b10 : 2'b01;
                r_d.last  = r_q.grant;
                r_d.state = IDLE;
            end
            default: begin
                r_d = ARB_RESET;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= ARB_RESET;
            uart_q <= '0;
        end else begin
            r_q    <= r_d;
            uart_q <= uart_d;
        end
    end

    assign uart_in = uart_q;

endmodule
